// File: rtl/row_pattern_gen_pkg.sv
// Shared types and constants for the row pattern generator.
// Mode encodings, FSM states and PRNG tap definition.
package row_gen_pkg;

    localparam int          PRNG_W    = 16;
    localparam logic [15:0] PRNG_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_FILL   = 2'b01,
        MODE_GAP    = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_BUILD,
        ST_COMMIT
    } state_e;

    // Smallest 2^k-1 covering every legal gap start position.
    function automatic int pos_mask(input int span);
        return (1 << $clog2(span + 1)) - 1;
    endfunction

endpackage

// File: rtl/row_pattern_gen_if.sv
// Control/status bundle between a line requester and the generator.
// The requester is the master; the generator is the slave.
interface row_pattern_gen_if #(
    parameter int WIDTH = 640
) ();

    logic             en_i;
    logic             req_i;
    logic [1:0]       mode_i;
    logic             seed_load_i;
    logic [15:0]      seed_i;
    logic [WIDTH-1:0] line_o;
    logic             busy_o;
    logic             valid_o;
    logic [15:0]      gap_pos_o;

    modport master (
        output en_i, req_i, mode_i, seed_load_i, seed_i,
        input  line_o, busy_o, valid_o, gap_pos_o
    );

    modport slave (
        input  en_i, req_i, mode_i, seed_load_i, seed_i,
        output line_o, busy_o, valid_o, gap_pos_o
    );

endinterface

// File: rtl/row_pattern_gen_prng.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting.
// Loads take priority over the shift in an enabled cycle.
module prng16
    import row_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [PRNG_W-1:0] load_val_i,
    output logic [PRNG_W-1:0] state_o,
    output logic              bit_o
);

    logic [PRNG_W-1:0] r_state;
    logic              w_fb;

    assign w_fb    = ^(r_state & PRNG_TAPS);
    assign state_o = r_state;
    assign bit_o   = r_state[0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= SEED;
        end else if (en_i) begin
            if (load_i) begin
                r_state <= load_val_i;
            end else begin
                r_state <= {w_fb, r_state[PRNG_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/row_pattern_gen.sv
// Line pattern generator: shift/fill/rotate in one cycle, or a
// chunk-built line carrying one GAP_W-wide hole at a random offset.
module row_pattern_gen
    import row_gen_pkg::*;
#(
    parameter int          WIDTH = 640,
    parameter int          CHUNK = 32,
    parameter int          GAP_W = 64,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input logic         clk_i,
    input logic         reset_i,
    row_pattern_gen_if.slave bus
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SPAN = WIDTH - GAP_W;
    localparam logic [15:0] MASK = 16'(pos_mask(SPAN));

    state_e           r_state;
    logic [WIDTH-1:0] r_line;
    logic [WIDTH-1:0] r_shadow;
    logic [15:0]      r_gap_pos;
    logic [15:0]      r_gap_pos_o;
    logic             r_valid;
    logic [CW-1:0]    r_chunk;

    mode_e            w_mode;
    logic             w_idle;
    logic             w_load;
    logic             w_prng_bit;
    logic [15:0]      w_prng;
    logic [15:0]      w_load_val;
    logic [15:0]      w_cand;
    logic [31:0]      w_base;
    logic [31:0]      w_lo;
    logic [31:0]      w_hi;
    logic [CHUNK-1:0] w_chunk;

    assign w_mode     = mode_e'(bus.mode_i);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_load     = bus.en_i & w_idle & bus.seed_load_i;
    assign w_load_val = (bus.seed_i == '0) ? SEED : bus.seed_i;
    assign w_cand     = w_prng & MASK;

    prng16 #(.SEED(SEED)) u_prng (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (bus.en_i),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .state_o    (w_prng),
        .bit_o      (w_prng_bit)
    );

    assign w_base = 32'(r_chunk) * 32'(CHUNK);
    assign w_lo   = {16'b0, r_gap_pos};
    assign w_hi   = w_lo + 32'(GAP_W);

    always_comb begin
        w_chunk = '1;
        for (int j = 0; j < CHUNK; j++) begin
            if (w_base + 32'(j) >= w_lo &&
                w_base + 32'(j) < w_hi) begin
                w_chunk[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_line      <= '1;
            r_shadow    <= '1;
            r_gap_pos   <= '0;
            r_gap_pos_o <= '0;
            r_valid     <= 1'b0;
            r_chunk     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.en_i) begin
                unique case (r_state)
                    ST_IDLE: begin
                        // A seed load swallows a same-cycle request.
                        if (!bus.seed_load_i && bus.req_i) begin
                            unique case (w_mode)
                                MODE_SHIFT: begin
                                    r_line <= (r_line == '0) ? '1 :
                                        {w_prng_bit, r_line[WIDTH-1:1]};
                                    r_valid <= 1'b1;
                                end
                                MODE_FILL: begin
                                    r_line  <= '1;
                                    r_valid <= 1'b1;
                                end
                                MODE_ROTATE: begin
                                    r_line  <= {r_line[0], r_line[WIDTH-1:1]};
                                    r_valid <= 1'b1;
                                end
                                MODE_GAP: begin
                                    r_state <= ST_PICK;
                                end
                            endcase
                        end
                    end
                    ST_PICK: begin
                        if (w_cand <= 16'(SPAN)) begin
                            r_gap_pos <= w_cand;
                            r_chunk   <= '0;
                            r_state   <= ST_BUILD;
                        end
                    end
                    ST_BUILD: begin
                        for (int k = 0; k < NCH; k++) begin
                            if (r_chunk == CW'(k)) begin
                                r_shadow[k*CHUNK +: CHUNK] <= w_chunk;
                            end
                        end
                        if (r_chunk == CW'(NCH - 1)) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                    ST_COMMIT: begin
                        r_line      <= r_shadow;
                        r_gap_pos_o <= r_gap_pos;
                        r_valid     <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.line_o    = r_line;
    assign bus.busy_o    = ~w_idle;
    assign bus.valid_o   = r_valid;
    assign bus.gap_pos_o = r_gap_pos_o;

endmodule
